// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave: default word length and FSM state encoding.
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_slave_if.sv
// Pin and word-level bus of the SPI slave; the slave modport is the RTL view, master is the driving side.
interface spi_slave_if
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH
);
  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_taken;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ack;
  logic                  overrun;
  logic                  overrun_clr;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, rx_ack, overrun_clr,
    output miso, miso_oe, tx_taken, rx_data, rx_valid, overrun
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, rx_ack, overrun_clr,
    input  miso, miso_oe, tx_taken, rx_data, rx_valid, overrun
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with single-cycle rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first; states ST_IDLE (deselected) | ST_SHIFT (framing words while cs_n low).
// Define SPI_SLAVE_OVERRUN_EN to enable the sticky overrun flag; otherwise overrun reads 0.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH
) (
  input logic        clk,
  input logic        rst,
  spi_slave_if.slave bus
);
  localparam int            CW   = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  spi_state_t            state;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-2:0] rx_sr;
  logic [DATA_WIDTH-1:0] rx_word;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic                  mosi_meta, mosi_sync;
  logic                  miso_q, miso_oe_q, tx_taken_q, rx_valid_q;
  logic                  word_done;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .d(bus.sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .d(bus.cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  // Same two-flop latency as sclk, so mosi_sync lines up with the rise pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      mosi_meta <= bus.mosi;
      mosi_sync <= mosi_meta;
    end
  end

  assign rx_word   = {rx_sr, mosi_sync};
  assign word_done = (state == ST_SHIFT) && !cs_rise && sclk_rise && (bit_cnt == LAST);

  // tx_sr holds the bits still to be sent, left-aligned; its MSB is always the next miso value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      tx_taken_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      tx_taken_q <= 1'b0;

      if (word_done) begin
        rx_data_q  <= rx_word;
        rx_valid_q <= 1'b1;
      end else if (bus.rx_ack) begin
        rx_valid_q <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state      <= ST_SHIFT;
            tx_sr      <= bus.tx_data << 1;
            miso_q     <= bus.tx_data[DATA_WIDTH-1];
            miso_oe_q  <= 1'b1;
            tx_taken_q <= 1'b1;
            bit_cnt    <= '0;
            rx_sr      <= '0;
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
          end else if (sclk_rise) begin
            rx_sr   <= rx_word[DATA_WIDTH-2:0];
            bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
          end else if (sclk_fall) begin
            if (bit_cnt == '0) begin
              tx_sr      <= bus.tx_data << 1;
              miso_q     <= bus.tx_data[DATA_WIDTH-1];
              tx_taken_q <= 1'b1;
            end else begin
              tx_sr  <= tx_sr << 1;
              miso_q <= tx_sr[DATA_WIDTH-1];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.miso     = miso_q;
  assign bus.miso_oe  = miso_oe_q;
  assign bus.tx_taken = tx_taken_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_OVERRUN_EN
  logic overrun_q;

  // A completing word takes priority over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (word_done && rx_valid_q && !bus.rx_ack) begin
      overrun_q <= 1'b1;
    end else if (bus.overrun_clr) begin
      overrun_q <= 1'b0;
    end
  end

  assign bus.overrun = overrun_q;
`else
  logic unused_overrun_clr;

  assign unused_overrun_clr = bus.overrun_clr;
  assign bus.overrun        = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: bit-banged mode-0 master, scoreboard queues for miso and rx words.
module tb_spi_slave;
  localparam int W    = 8;
  localparam int HALF = 4;

`ifdef SPI_SLAVE_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  spi_slave_if #(.DATA_WIDTH(W)) bus ();

  spi_slave #(.DATA_WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         n_checks  = 0;
  int         n_errors  = 0;
  int         taken_cnt = 0;
  bit         auto_ack  = 1'b0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  logic [7:0] tx_next[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Supplies the next queued tx word after each capture and counts captures.
  initial forever begin
    @(negedge clk);
    if (bus.tx_taken === 1'b1) begin
      taken_cnt++;
      if (tx_next.size() > 0) bus.tx_data = tx_next.pop_front();
    end
  end

  // Consumer: compares each presented word against the scoreboard and acknowledges it.
  initial forever begin
    @(negedge clk);
    if (auto_ack) begin
      if (bus.rx_ack) begin
        bus.rx_ack = 1'b0;
      end else if (bus.rx_valid === 1'b1) begin
        if (exp_rx.size() == 0) check("rx_extra", bus.rx_data, 32'hFFFF_FFFF);
        else check("rx_word", bus.rx_data, exp_rx.pop_front());
        bus.rx_ack = 1'b1;
      end
    end
  end

  task automatic expect_rx(input string tag);
    if (exp_rx.size() == 0) check({tag, "_empty"}, 1, 0);
    else check(tag, bus.rx_data, exp_rx.pop_front());
  endtask

  task automatic ack_manual();
    @(negedge clk);
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    check("rx_valid_after_ack", bus.rx_valid, 0);
  endtask

  task automatic spi_word(input logic [7:0] mo, input int nbits, input bit hold_last,
                          input bit ack_last, output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      bus.mosi = mo[i];
      repeat (HALF) @(negedge clk);
      mi[i]    = bus.miso;
      bus.sclk = 1'b1;
      for (int k = 0; k < HALF; k++) begin
        @(negedge clk);
        if (ack_last && i == 8 - nbits) begin
          if (k == 1) bus.rx_ack = 1'b1;
          if (k == 2) bus.rx_ack = 1'b0;
        end
      end
      if (!(hold_last && i == 8 - nbits)) bus.sclk = 1'b0;
    end
  endtask

  // cs_n rises while sclk is still high, so the trailing sclk fall lands in IDLE.
  task automatic end_frame();
    repeat (HALF) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic frame(input int n, input logic [7:0] mo0, input logic [7:0] mo1,
                       input logic [7:0] tx0, input logic [7:0] tx1,
                       input bit push_rx, input bit ack_last);
    logic [7:0] mi;
    bus.tx_data = tx0;
    exp_miso.push_back(tx0);
    if (n > 1) begin
      tx_next.push_back(tx1);
      exp_miso.push_back(tx1);
    end
    if (push_rx) begin
      exp_rx.push_back(mo0);
      if (n > 1) exp_rx.push_back(mo1);
    end
    @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int w = 0; w < n; w++) begin
      spi_word((w == 0) ? mo0 : mo1, 8, w == n - 1, ack_last && (w == n - 1), mi);
      if (exp_miso.size() == 0) check("miso_empty", 1, 0);
      else check("miso_word", mi, exp_miso.pop_front());
    end
    end_frame();
  endtask

  initial begin
    int         t0;
    logic [7:0] mi;

    rst             = 1'b1;
    bus.sclk        = 1'b0;
    bus.cs_n        = 1'b1;
    bus.mosi        = 1'b0;
    bus.tx_data     = '0;
    bus.rx_ack      = 1'b0;
    bus.overrun_clr = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_miso", bus.miso, 0);
    check("rst_miso_oe", bus.miso_oe, 0);
    check("rst_tx_taken", bus.tx_taken, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_overrun", bus.overrun, 0);

    // Single word, no consumer: word must be held.
    t0 = taken_cnt;
    frame(1, 8'h3C, 8'h00, 8'hA5, 8'h00, 1'b1, 1'b0);
    expect_rx("single_rx_data");
    check("single_rx_valid", bus.rx_valid, 1);
    check("single_taken", taken_cnt - t0, 1);
    check("single_miso_oe", bus.miso_oe, 0);
    check("single_miso_idle", bus.miso, 0);
    ack_manual();

    // Two back-to-back words with a live consumer.
    auto_ack = 1'b1;
    t0 = taken_cnt;
    frame(2, 8'h81, 8'h7E, 8'h11, 8'h22, 1'b1, 1'b0);
    check("multi_taken", taken_cnt - t0, 2);
    check("multi_drain", exp_rx.size(), 0);

    // Deselect after 5 bits: partial word dropped.
    t0 = taken_cnt;
    bus.tx_data = 8'h00;
    @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_word(8'hFF, 5, 1'b1, 1'b0, mi);
    end_frame();
    check("partial_rx_valid", bus.rx_valid, 0);
    check("partial_rx_data", bus.rx_data, 8'h7E);
    check("partial_miso_oe", bus.miso_oe, 0);
    check("partial_miso", bus.miso, 0);
    check("partial_taken", taken_cnt - t0, 1);
    frame(1, 8'hC3, 8'h00, 8'h96, 8'h00, 1'b1, 1'b0);
    check("partial_drain", exp_rx.size(), 0);

    // Two words without acknowledge.
    auto_ack = 1'b0;
    frame(2, 8'h12, 8'h34, 8'h55, 8'hAA, 1'b0, 1'b0);
    check("ovr_rx_valid", bus.rx_valid, 1);
    check("ovr_rx_data", bus.rx_data, 8'h34);
    check("ovr_flag", bus.overrun, OVR_EXP);
    @(negedge clk);
    bus.overrun_clr = 1'b1;
    @(negedge clk);
    bus.overrun_clr = 1'b0;
    check("ovr_cleared", bus.overrun, 0);
    ack_manual();

    // Acknowledge lands on the same cycle the second word completes.
    frame(2, 8'h18, 8'hE7, 8'h0F, 8'hF0, 1'b0, 1'b1);
    check("coinc_rx_valid", bus.rx_valid, 1);
    check("coinc_rx_data", bus.rx_data, 8'hE7);
    check("coinc_overrun", bus.overrun, 0);
    ack_manual();

    // Asynchronous reset in the middle of a word.
    auto_ack    = 1'b1;
    bus.tx_data = 8'h99;
    @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_word(8'hC0, 3, 1'b1, 1'b0, mi);
    check("pre_rst_miso_oe", bus.miso_oe, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_miso", bus.miso, 0);
    check("arst_miso_oe", bus.miso_oe, 0);
    check("arst_tx_taken", bus.tx_taken, 0);
    check("arst_rx_data", bus.rx_data, 0);
    check("arst_rx_valid", bus.rx_valid, 0);
    check("arst_overrun", bus.overrun, 0);
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    frame(1, 8'h5A, 8'h00, 8'h3C, 8'h00, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("post_rst_drain", exp_rx.size(), 0);
    check("post_rst_rx_data", bus.rx_data, 8'h5A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
